oflow_buffer_read_sequencer: RTL and testbench
==============================================

# oflow_buffer_read_sequencer

Read-side sequencer between the MEM buffer and the PE array. On a start pulse it walks the history frames, issues one row read per cycle to the buffer, and splits each returned row into two PE entries. Each entry has the frame's d_history value inserted between its feature field and its ID field. Entries stream to the PEs over a valid/ready handshake, so this block is the counterpart of the PE-to-buffer write packing path.

## Interface
Parameters:
- FEAT_LEN, 142: stored feature width per object; ID is in its low bits.
- ID_LEN, 12: object ID width.
- HIST_W, 3: d_history / history frame index width.
- ROW_W, 6: row address width within a frame.
- CNT_W, 7: object count width.

Ports:
- clk  in  1  clock.
- reset_N  in  1  synchronous, active-high reset, despite the name.
- start  in  1  one-cycle pulse; ignored unless busy=0.
- num_hist_frames  in  HIST_W  number of history frames to read (0..7), latched on start.
- hist_idx  out  HIST_W  frame currently being fetched (1..num_hist_frames); reset 0.
- hist_obj_cnt  in  CNT_W  object count of frame hist_idx; valid in the same cycle (combinational lookup).
- rd_en  out  1  buffer read strobe; reset 0.
- rd_frame  out  HIST_W  frame of the read; reset 0.
- rd_row  out  ROW_W  row of the read; reset 0.
- rd_data  in  2*FEAT_LEN  buffer row, valid exactly 1 cycle after rd_en.
- pe_valid  out  2  per-lane valid; bit1 requires bit0; reset 0.
- pe_ready  in  1  PE accepts both lanes when pe_valid[0]&&pe_ready.
- data_to_pe_0, data_to_pe_1  out  FEAT_LEN+HIST_W  lane payloads; reset 0.
- busy  out  1  high outside IDLE; reset 0.
- done  out  1  one-cycle pulse at completion; reset 0.

## Operation
- Lane split: entry0 = rd_data[2*FEAT_LEN-1:FEAT_LEN], entry1 = rd_data[FEAT_LEN-1:0].
- Lane payload: {entry[FEAT_LEN-1:ID_LEN], hist, entry[ID_LEN-1:0]}, where hist is the rd_frame of the originating read, carried with the read.
- Rows per frame = ceil(hist_obj_cnt/2).
  - Last row with odd count: pe_valid=2'b01, data_to_pe_1 forced to 0.
  - Otherwise pe_valid=2'b11.
- FSM states:
  - IDLE: on start, latch num_hist_frames and set hist_idx=1. If num_hist_frames=0, go to DONE; else go to FETCH.
  - FETCH: issue reads rd_row=0.. for frame hist_idx while a credit is available.
    - After the frame's last row issues, increment hist_idx.
    - A frame with hist_obj_cnt=0 is skipped in one cycle with no read.
    - After the last row of frame num_hist_frames, or a skip of it, go to DRAIN.
  - DRAIN: when no read is in flight and the output buffer is empty, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE. hist_idx returns to 0.
- Credits:
  - Output storage is 2 rows: output register plus skid register.
  - rd_en may assert only if occupied entries + in-flight reads < 2, counting an entry being accepted this cycle as freed.
  - Overflow of the output storage is impossible by construction.
- Order: rows are delivered in issue order. Frame 1 rows precede frame 2 rows.
- Output stability: while pe_valid[0]&&!pe_ready, payloads and pe_valid are held stable.
- start while busy is ignored.
- Reset mid-operation: return to IDLE, drop in-flight data, clear all outputs, no done pulse.

## Timing
- Read latency: rd_data sampled 1 cycle after rd_en, loaded at that edge, pe_valid visible the following cycle.
- start to first rd_en: 1 cycle (rd_en asserted in the cycle after start).
- First rd_en to first pe_valid: 2 cycles.
- Throughput with the skid buffer and pe_ready held high: 1 row/cycle sustained.
- done asserts 1 cycle after the last row is accepted.
- A zero-object frame costs 1 cycle.

## Configuration
- OFLOW_RD_SEQ_SKID_EN defined: 2-entry output storage, credit limit 2, 1 row/cycle sustained.
- Undefined: single output register, credit limit 1, at most one read outstanding, 1 row per 2 cycles max.
- Data, ordering and done behaviour are identical in both builds.

## Test plan
- num_hist_frames=2, counts {4,3}, pe_ready=1:
  - reads (f1,r0),(f1,r1),(f2,r0),(f2,r1) on consecutive cycles;
  - pe_valid 11,11,11,01;
  - d_history 1,1,2,2;
  - lane1 of the last row = 0;
  - done 1 cycle after the last accept.
- Payload check: rd_data with entry0 = {0x3FF..., ID 0xABC}, hist=3 -> data_to_pe_0 = {entry0[141:12], 3'b011, 12'hABC}.
- Backpressure: pe_ready=0 for 5 cycles mid-stream -> at most 2 rows buffered, no rd_en beyond credits, payload held stable, no loss or duplication after release.
- Boundary cases:
  - num_hist_frames=0 -> done 1 cycle after start, no rd_en.
  - counts {0,2} -> frame 1 skipped, single row from frame 2 with hist=2.
- Reset asserted with 2 reads in flight -> next cycle all outputs 0, busy=0, no done; a fresh start then runs correctly.
- start pulsed while busy -> ignored, the sequence completes unchanged. In a build without OFLOW_RD_SEQ_SKID_EN, rd_en is never asserted in two consecutive cycles.

Source files
------------

// File: rtl/oflow_buffer_read_sequencer.sv
// oflow_buffer_read_sequencer
//
// Read-side sequencer between the MEM buffer and the PE array. A start pulse
// walks history frames 1..num_hist_frames and issues one row read per cycle
// while output credits allow. Each returned row is split into two PE entries.
// The originating frame index (d_history) is inserted between each entry's
// feature field and its ID field. Entries stream out over valid/ready.
//
// Build option:
//   OFLOW_RD_SEQ_SKID_EN  defined   -> output register + skid register,
//                                      2 credits, 1 row/cycle sustained
//                         undefined -> single output register, 1 credit
//
// Ports:
//   clk, reset_N       clock; synchronous active-high reset (despite the name)
//   start              one-cycle start pulse, ignored while busy
//   num_hist_frames    number of frames to read, latched on start
//   hist_idx           frame currently being fetched (0 when idle)
//   hist_obj_cnt       object count of frame hist_idx (combinational lookup)
//   rd_en/rd_frame/rd_row  buffer read strobe and address
//   rd_data            buffer row, valid one cycle after rd_en
//   pe_valid[1:0]      lane valids, bit1 implies bit0
//   pe_ready           both lanes accepted when pe_valid[0] && pe_ready
//   data_to_pe_0/1     lane payloads {feature, hist, id}
//   busy, done         busy outside idle; done is a one-cycle completion pulse
module oflow_buffer_read_sequencer #(
  parameter int unsigned FEAT_LEN = 142,
  parameter int unsigned ID_LEN   = 12,
  parameter int unsigned HIST_W   = 3,
  parameter int unsigned ROW_W    = 6,
  parameter int unsigned CNT_W    = 7
) (
  input  logic                       clk,
  input  logic                       reset_N,
  input  logic                       start,
  input  logic [HIST_W-1:0]          num_hist_frames,
  output logic [HIST_W-1:0]          hist_idx,
  input  logic [CNT_W-1:0]           hist_obj_cnt,
  output logic                       rd_en,
  output logic [HIST_W-1:0]          rd_frame,
  output logic [ROW_W-1:0]           rd_row,
  input  logic [2*FEAT_LEN-1:0]      rd_data,
  output logic [1:0]                 pe_valid,
  input  logic                       pe_ready,
  output logic [FEAT_LEN+HIST_W-1:0] data_to_pe_0,
  output logic [FEAT_LEN+HIST_W-1:0] data_to_pe_1,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned PayW = FEAT_LEN + HIST_W;
`ifdef OFLOW_RD_SEQ_SKID_EN
  localparam int unsigned Credits = 2;
`else
  localparam int unsigned Credits = 1;
`endif

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [HIST_W-1:0] num_frames_q, num_frames_d;
  logic [HIST_W-1:0] hist_idx_q, hist_idx_d;
  logic [ROW_W-1:0]  row_q, row_d;

  // Read in flight: its frame and whether it is an odd-count final row travel with it.
  logic              inflight_q;
  logic [HIST_W-1:0] inflight_hist_q;
  logic              inflight_half_q;

  logic              out_valid_q, out_valid_d;
  logic              out_half_q, out_half_d;
  logic [PayW-1:0]   out_d0_q, out_d0_d, out_d1_q, out_d1_d;
`ifdef OFLOW_RD_SEQ_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic              skid_half_q, skid_half_d;
  logic [PayW-1:0]   skid_d0_q, skid_d0_d, skid_d1_q, skid_d1_d;
`endif

  logic              accept;
  logic [2:0]        committed;
  logic              credit_ok;
  logic              frame_empty;
  logic              last_frame;
  logic [CNT_W-1:0]  last_row;
  logic              row_is_last;
  logic              row_is_half;
  logic [PayW-1:0]   in_d0, in_d1;

  function automatic logic [PayW-1:0] pack_entry(input logic [FEAT_LEN-1:0] entry,
                                                 input logic [HIST_W-1:0]   hist);
    return {entry[FEAT_LEN-1:ID_LEN], hist, entry[ID_LEN-1:0]};
  endfunction

  always_comb begin
    accept = out_valid_q & pe_ready;
    // Rows that will still hold storage after this cycle, including the read in flight.
`ifdef OFLOW_RD_SEQ_SKID_EN
    committed = 3'(out_valid_q) + 3'(skid_valid_q) - 3'(accept) + 3'(inflight_q);
`else
    committed = 3'(out_valid_q) - 3'(accept) + 3'(inflight_q);
`endif
    credit_ok   = committed < 3'(Credits);
    frame_empty = hist_obj_cnt == '0;
    last_frame  = hist_idx_q == num_frames_q;
    last_row    = (hist_obj_cnt - CNT_W'(1)) >> 1;
    row_is_last = CNT_W'(row_q) == last_row;
    row_is_half = row_is_last & hist_obj_cnt[0];
    rd_en       = (state_q == StFetch) & ~frame_empty & credit_ok;
  end

  // Sequencing FSM
  always_comb begin
    state_d      = state_q;
    num_frames_d = num_frames_q;
    hist_idx_d   = hist_idx_q;
    row_d        = row_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          num_frames_d = num_hist_frames;
          hist_idx_d   = HIST_W'(1);
          row_d        = '0;
          state_d      = (num_hist_frames == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (frame_empty) begin
          if (last_frame) state_d = StDrain;
          else            hist_idx_d = hist_idx_q + HIST_W'(1);
        end else if (rd_en) begin
          if (row_is_last) begin
            row_d = '0;
            if (last_frame) state_d = StDrain;
            else            hist_idx_d = hist_idx_q + HIST_W'(1);
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      StDrain: begin
        // Counting this cycle's accept lets done follow the last accept by one cycle.
        if (committed == '0) state_d = StDone;
      end
      default: begin
        state_d    = StIdle;
        hist_idx_d = '0;
      end
    endcase
  end

  // Output storage: pop on accept, refill from skid first, then from the returning row.
  always_comb begin
    in_d0 = pack_entry(rd_data[2*FEAT_LEN-1:FEAT_LEN], inflight_hist_q);
    in_d1 = inflight_half_q ? '0 : pack_entry(rd_data[FEAT_LEN-1:0], inflight_hist_q);

    out_valid_d = out_valid_q;
    out_half_d  = out_half_q;
    out_d0_d    = out_d0_q;
    out_d1_d    = out_d1_q;
    if (accept) out_valid_d = 1'b0;
`ifdef OFLOW_RD_SEQ_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_half_d  = skid_half_q;
    skid_d0_d    = skid_d0_q;
    skid_d1_d    = skid_d1_q;
    if (accept && skid_valid_q) begin
      out_valid_d  = 1'b1;
      out_half_d   = skid_half_q;
      out_d0_d     = skid_d0_q;
      out_d1_d     = skid_d1_q;
      skid_valid_d = 1'b0;
    end
    if (inflight_q) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_half_d  = inflight_half_q;
        out_d0_d    = in_d0;
        out_d1_d    = in_d1;
      end else begin
        skid_valid_d = 1'b1;
        skid_half_d  = inflight_half_q;
        skid_d0_d    = in_d0;
        skid_d1_d    = in_d1;
      end
    end
`else
    if (inflight_q) begin
      out_valid_d = 1'b1;
      out_half_d  = inflight_half_q;
      out_d0_d    = in_d0;
      out_d1_d    = in_d1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q         <= StIdle;
      num_frames_q    <= '0;
      hist_idx_q      <= '0;
      row_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_hist_q <= '0;
      inflight_half_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_half_q      <= 1'b0;
      out_d0_q        <= '0;
      out_d1_q        <= '0;
`ifdef OFLOW_RD_SEQ_SKID_EN
      skid_valid_q    <= 1'b0;
      skid_half_q     <= 1'b0;
      skid_d0_q       <= '0;
      skid_d1_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      num_frames_q    <= num_frames_d;
      hist_idx_q      <= hist_idx_d;
      row_q           <= row_d;
      inflight_q      <= rd_en;
      inflight_hist_q <= hist_idx_q;
      inflight_half_q <= row_is_half;
      out_valid_q     <= out_valid_d;
      out_half_q      <= out_half_d;
      out_d0_q        <= out_d0_d;
      out_d1_q        <= out_d1_d;
`ifdef OFLOW_RD_SEQ_SKID_EN
      skid_valid_q    <= skid_valid_d;
      skid_half_q     <= skid_half_d;
      skid_d0_q       <= skid_d0_d;
      skid_d1_q       <= skid_d1_d;
`endif
    end
  end

  assign hist_idx     = hist_idx_q;
  assign rd_frame     = hist_idx_q;
  assign rd_row       = row_q;
  assign pe_valid     = {out_valid_q & ~out_half_q, out_valid_q};
  assign data_to_pe_0 = out_d0_q;
  assign data_to_pe_1 = out_d1_q;
  assign busy         = state_q != StIdle;
  assign done         = state_q == StDone;

endmodule

// File: tb/tb_oflow_buffer_read_sequencer.sv
module tb_oflow_buffer_read_sequencer;
  localparam int FL = 142;
  localparam int IL = 12;
  localparam int HW = 3;
  localparam int RW = 6;
  localparam int CW = 7;
  localparam int PW = FL + HW;
  localparam int DW = 2 * FL;
`ifdef OFLOW_RD_SEQ_SKID_EN
  localparam int Credits = 2;
`else
  localparam int Credits = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_N;
  logic          start;
  logic [HW-1:0] num_hist_frames;
  logic [HW-1:0] hist_idx;
  logic [CW-1:0] hist_obj_cnt;
  logic          rd_en;
  logic [HW-1:0] rd_frame;
  logic [RW-1:0] rd_row;
  logic [DW-1:0] rd_data;
  logic [1:0]    pe_valid;
  logic          pe_ready;
  logic [PW-1:0] data_to_pe_0;
  logic [PW-1:0] data_to_pe_1;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  oflow_buffer_read_sequencer #(
    .FEAT_LEN(FL), .ID_LEN(IL), .HIST_W(HW), .ROW_W(RW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .num_hist_frames(num_hist_frames),
    .hist_idx(hist_idx), .hist_obj_cnt(hist_obj_cnt), .rd_en(rd_en), .rd_frame(rd_frame),
    .rd_row(rd_row), .rd_data(rd_data), .pe_valid(pe_valid), .pe_ready(pe_ready),
    .data_to_pe_0(data_to_pe_0), .data_to_pe_1(data_to_pe_1), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [1:0]    v;
    logic [PW-1:0] d0;
    logic [PW-1:0] d1;
  } ent_t;

  int            compared = 0;
  int            mismatched = 0;
  logic [DW-1:0] mem [8][64];
  int            counts [8];
  ent_t          exp_q [$];
  int            rdq_f [$];
  int            rdq_r [$];
  logic          rd_pend;
  logic [HW-1:0] rd_pf;
  logic [RW-1:0] rd_pr;
  logic [PW-1:0] first_d0;

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w = {w[DW-33:0], $urandom};
    return w;
  endfunction

  function automatic logic [PW-1:0] lane(input logic [FL-1:0] e, input int f);
    logic [HW-1:0] h;
    h = HW'(f);
    return {e[FL-1:IL], h, e[IL-1:0]};
  endfunction

  // Advance one clock; the buffer answers the previous cycle's read, counts follow hist_idx.
  task automatic tick(input logic st, input logic rdy);
    @(posedge clk);
    #1;
    rd_data      = rd_pend ? mem[rd_pf][rd_pr] : rand_word();
    hist_obj_cnt = CW'(counts[hist_idx]);
    start        = st;
    pe_ready     = rdy;
    #1;
    rd_pend = rd_en;
    rd_pf   = rd_frame;
    rd_pr   = rd_row;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_frame"}, rd_frame, 0);
    chk({tag, "_rd_row"}, rd_row, 0);
    chk({tag, "_hist_idx"}, hist_idx, 0);
    chk({tag, "_pe_valid"}, pe_valid, 0);
    chk({tag, "_data0"}, data_to_pe_0, 0);
    chk({tag, "_data1"}, data_to_pe_1, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run(input string tag, input int nf, input int rdy_pct, input bit hold5,
                     input bit extra_start, input bit chk_timing);
    int            issued, accepted, last_acc, first_pv;
    int            rd_cycs [$];
    bit            got_done, prev_stall, prev_rd, rdy, acc, odd;
    logic [1:0]    pv_h;
    logic [PW-1:0] d0_h, d1_h;
    logic [DW-1:0] w;
    ent_t          e;

    // Expected stream straight from the frame/row rules.
    exp_q.delete();
    rdq_f.delete();
    rdq_r.delete();
    for (int f = 1; f <= nf; f++) begin
      for (int r = 0; r < (counts[f] + 1) / 2; r++) begin
        w    = mem[f][r];
        odd  = (2 * r + 1) == counts[f];
        e.v  = odd ? 2'b01 : 2'b11;
        e.d0 = lane(w[DW-1:FL], f);
        e.d1 = odd ? '0 : lane(w[FL-1:0], f);
        exp_q.push_back(e);
        rdq_f.push_back(f);
        rdq_r.push_back(r);
      end
    end

    num_hist_frames = HW'(nf);
    tick(1'b1, 1'b1);
    issued = 0; accepted = 0; last_acc = -1; first_pv = -1;
    got_done = 0; prev_stall = 0; prev_rd = 0;
    pv_h = '0; d0_h = '0; d1_h = '0;
    for (int cyc = 1; cyc <= 600 && !got_done; cyc++) begin
      rdy = (hold5 && cyc >= 6 && cyc <= 10) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (extra_start && cyc == 3) num_hist_frames = HW'(nf ^ 5);
      tick(extra_start && cyc == 3, rdy);
      num_hist_frames = HW'(nf);
      acc = pe_valid[0] && rdy;
      if (pe_valid[0] && first_pv < 0) first_pv = cyc;
      if (prev_stall)
        chk({tag, "_hold"}, {pe_valid, data_to_pe_0, data_to_pe_1}, {pv_h, d0_h, d1_h});
      if (rd_en) begin
        chk({tag, "_credit"}, (issued - accepted - int'(acc)) < Credits, 1);
        if (rdq_f.size() > 0) begin
          chk({tag, "_rd_addr"}, {rd_frame, rd_row}, {HW'(rdq_f[0]), RW'(rdq_r[0])});
          void'(rdq_f.pop_front());
          void'(rdq_r.pop_front());
        end else begin
          chk({tag, "_rd_extra"}, rdq_f.size(), 1);
        end
`ifndef OFLOW_RD_SEQ_SKID_EN
        chk({tag, "_rd_gap"}, prev_rd, 0);
`endif
        issued++;
        rd_cycs.push_back(cyc);
      end
      if (acc) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, "_pe_valid"}, pe_valid, e.v);
          chk({tag, "_data0"}, data_to_pe_0, e.d0);
          chk({tag, "_data1"}, data_to_pe_1, e.d1);
          if (accepted == 0) first_d0 = data_to_pe_0;
        end else begin
          chk({tag, "_pe_extra"}, exp_q.size(), 1);
        end
        accepted++;
        last_acc = cyc;
      end
      if (done) begin
        got_done = 1;
        if (last_acc >= 0) chk({tag, "_done_lat"}, cyc, last_acc + 1);
        else if (nf == 0)  chk({tag, "_done_lat"}, cyc, 1);
        chk({tag, "_left_rows"}, exp_q.size(), 0);
        chk({tag, "_left_reads"}, rdq_f.size(), 0);
      end
      prev_stall = pe_valid[0] && !rdy;
      pv_h = pe_valid; d0_h = data_to_pe_0; d1_h = data_to_pe_1;
      prev_rd = rd_en;
    end
    chk({tag, "_done_seen"}, got_done, 1);
    if (chk_timing && rd_cycs.size() >= 4) begin
      chk({tag, "_first_rd"}, rd_cycs[0], 1);
      chk({tag, "_first_pv"}, first_pv, rd_cycs[0] + 2);
`ifdef OFLOW_RD_SEQ_SKID_EN
      chk({tag, "_b2b_reads"}, rd_cycs[3], 4);
`endif
    end
    tick(1'b0, 1'b1);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hist_idx0"}, hist_idx, 0);
  endtask

  initial begin
    logic [FL-1:0] e0;
    logic [PW-1:0] pay;
    reset_N = 1'b1; start = 1'b0; num_hist_frames = '0; hist_obj_cnt = '0;
    pe_ready = 1'b0; rd_data = '0; rd_pend = 1'b0; rd_pf = '0; rd_pr = '0; first_d0 = '0;
    for (int f = 0; f < 8; f++) begin
      counts[f] = 0;
      for (int r = 0; r < 64; r++) mem[f][r] = rand_word();
    end

    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_zero("por");
    reset_N = 1'b0;

    // Two frames {4,3}, always ready.
    counts[1] = 4; counts[2] = 3;
    run("basic", 2, 100, 1'b0, 1'b0, 1'b1);

    // Payload layout, single odd row in frame 3.
    counts[1] = 0; counts[2] = 0; counts[3] = 1;
    e0 = {{(FL - IL){1'b1}}, 12'hABC};
    mem[3][0][DW-1:FL] = e0;
    run("payload", 3, 100, 1'b0, 1'b0, 1'b0);
    pay = {{(FL - IL){1'b1}}, 3'b011, 12'hABC};
    chk("payload_const", first_d0, pay);

    run("zero_frames", 0, 100, 1'b0, 1'b0, 1'b0);

    counts[1] = 0; counts[2] = 2;
    run("skip", 2, 100, 1'b0, 1'b0, 1'b0);

    // Backpressure hole mid-stream plus a start pulse while busy.
    counts[1] = 6; counts[2] = 5; counts[3] = 4;
    run("bp", 3, 100, 1'b1, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int nf;
      nf = $urandom_range(7, 1);
      for (int f = 1; f < 8; f++) counts[f] = $urandom_range(12, 0);
      run("rand", nf, $urandom_range(100, 30), 1'b0, 1'b0, 1'b0);
    end

    // Reset with reads outstanding.
    counts[1] = 4; counts[2] = 4;
    num_hist_frames = 3'd2;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset_N = 1'b1;
    tick(1'b0, 1'b0);
    check_zero("midrst");
    reset_N = 1'b0;
    tick(1'b0, 1'b1);
    chk("midrst_no_done", done, 0);
    chk("midrst_no_valid", pe_valid, 0);
    run("after_rst", 2, 100, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
